sfx_player: RTL and testbench
=============================

# sfx_player

Parametrised, priority-arbitrated sound-effect sequencer for the game's beeper output. It holds NUM_SFX effects, each a short fixed sequence of square-wave notes. A one-cycle trigger plays an effect note by note and drives a single `beep` line to the piezo or speaker pin. It replaces the per-effect, single-purpose tone blocks with one table-driven engine that supports preemption, early end markers and mute.

## Interface
- NUM_SFX, 4: number of effects; index 0 has the highest priority.
- NOTES, 4: note slots per effect.
- DIV_W, 16: half-period divisor width.
- DUR_W, 16: note duration width, counted in beep toggles.
- NOTE_TABLE, all zeros: packed table, NUM_SFX*NOTES*(DIV_W+DUR_W) bits.
  - Entry e = s*NOTES+n sits at bits [e*(DIV_W+DUR_W) +: DIV_W+DUR_W].
  - The divisor is in the upper DIV_W bits; the duration is in the lower DUR_W bits.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- trig  in  NUM_SFX  one-cycle start pulses, one bit per effect.
- mute  in  1  when high, beep is held low; sequencing continues.
- beep  out  1  square-wave output, registered.
- busy  out  1  high while an effect is loading or playing.
- sfx_id  out  clog2(NUM_SFX) (min 1)  index of the current or last effect.
- done  out  1  one-cycle pulse when an effect completes naturally.

## Operation
- States: IDLE, LOAD, PLAY.
- Registers:
  - cnt (DIV_W), the half-period counter.
  - tog (DUR_W), toggles elapsed in the current note.
  - idx, the note index.
  - sfx_id.
  - div_r and dur_r, the current note.
- Arbitration on every edge. The winner w is the lowest set bit of trig.
  - It is accepted in IDLE, or in LOAD/PLAY when w <= sfx_id (equal or higher priority).
  - On accept: state goes to LOAD, sfx_id = w, idx = 0, beep = 0, busy = 1.
  - An accept overrides every other transition on that edge.
- Lower-priority triggers while busy are dropped; they are not queued.
- Retriggering the playing effect restarts it from note 0.
- LOAD reads entry (sfx_id, idx).
  - Divisor 0: go to IDLE with no done pulse (empty effect).
  - Otherwise: load div_r and dur_r, set cnt = 0 and tog = 0, go to PLAY.
- PLAY, each cycle:
  - If cnt == div_r-1: cnt = 0, beep toggles (unless muted), tog increments.
  - Otherwise cnt increments.
- Note end is the toggle edge where tog == max(dur_r,1)-1. Duration 0 is treated as 1.
  - If idx == NOTES-1, or the divisor of entry idx+1 is 0 (end marker): go to IDLE, beep = 0, busy = 0, done = 1 for one cycle.
  - Otherwise: idx increments, the next entry loads on the same edge, cnt = 0, tog = 0, and the state stays in PLAY. There is no gap cycle.
- Half-period = div_r clk cycles; tone frequency = f_clk / (2*div_r). Divisor 1 toggles every cycle.
- mute: the internal phase keeps toggling, but the beep register loads 0 whenever mute is high. On unmute, beep resumes at the next toggle edge with the internal phase.
- beep is always 0 in IDLE, including after odd durations.
- All arithmetic is unsigned and wrap-free.
  - cnt never exceeds div_r-1.
  - tog never exceeds dur_r-1.

## Timing
- Reset, asynchronous and immediate: state IDLE, beep 0, busy 0, done 0, sfx_id 0, and all counters 0. Reset mid-effect aborts the effect with no done pulse.
- trig accepted at edge k:
  - busy is high after k.
  - The first note loads at k+1.
  - The first beep toggle is at k+1+div.
- At note change, the new note's first toggle is div_new cycles after the last toggle of the old note.
- done and busy deasserting are simultaneous, on the final toggle edge.
- Triggers in the same cycle as completion are accepted: the state goes to LOAD, not IDLE, and done is still pulsed.

## Test plan
Bench parameters: NUM_SFX=2, NOTES=2, DIV_W=8, DUR_W=8. Table:
- sfx0 = {(3,4), (2,2)}.
- sfx1 = {(5,2), (0,x)}.

Scenarios:
- trig=01 at edge k:
  - beep toggles at k+4, k+7, k+10, k+13, k+15, k+17.
  - done pulses at k+17; busy low after k+17; beep 0 after.
- trig=10 at k:
  - Toggles at k+6 and k+11.
  - The end marker ends the effect: done at k+11, sfx_id=1.
- Preemption:
  - sfx1 playing, trig=01 at k+8: restarts as sfx0, first toggle at k+12, no done for sfx1.
  - sfx0 playing, trig=10: ignored; the sequence is unchanged.
- trig=11 simultaneously from IDLE: sfx0 plays.
- Retrigger sfx0 at k+9: it restarts at note 0, with toggles at k+13, k+16, ...
- mute high from k+5 to k+9 during sfx0: beep stays 0 in that window; toggle timing after k+9 is unchanged.
- rst pulse mid-note: beep, busy and done go to 0 immediately; the next trig plays from note 0.

Source files
------------

// File: rtl/sfx_player.sv
// Table-driven square-wave sound-effect sequencer with priority preemption.
// Each effect is a fixed list of (half-period divisor, toggle count) notes.
module sfx_player #(
  parameter int NUM_SFX = 4,
  parameter int NOTES   = 4,
  parameter int DIV_W   = 16,
  parameter int DUR_W   = 16,
  parameter logic [NUM_SFX*NOTES*(DIV_W+DUR_W)-1:0] NOTE_TABLE = '0,
  localparam int ID_W   = (NUM_SFX > 1) ? $clog2(NUM_SFX) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SFX-1:0] trig,
  input  logic               mute,
  output logic               beep,
  output logic               busy,
  output logic [ID_W-1:0]    sfx_id,
  output logic               done
);

  localparam int IDX_W = (NOTES > 1) ? $clog2(NOTES) : 1;
  localparam int ENT_W = DIV_W + DUR_W;

  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

  state_t            state_reg, state_next;
  logic [DIV_W-1:0]  cnt_reg, cnt_next;
  logic [DUR_W-1:0]  tog_reg, tog_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [ID_W-1:0]   sfx_id_reg, sfx_id_next;
  logic [DIV_W-1:0]  div_reg, div_next;
  logic [DUR_W-1:0]  dur_reg, dur_next;
  logic              phase_reg, phase_next;
  logic              beep_reg, beep_next;
  logic              done_reg, done_next;

  // Unpack the flat parameter table into per-effect, per-note lookups.
  logic [DIV_W-1:0] div_tab [NUM_SFX][NOTES];
  logic [DUR_W-1:0] dur_tab [NUM_SFX][NOTES];

  for (genvar gi = 0; gi < NUM_SFX*NOTES; gi++) begin : g_tab
    assign div_tab[gi/NOTES][gi%NOTES] = NOTE_TABLE[gi*ENT_W+DUR_W +: DIV_W];
    assign dur_tab[gi/NOTES][gi%NOTES] = NOTE_TABLE[gi*ENT_W +: DUR_W];
  end

  logic [IDX_W-1:0] idx_inc;
  logic             last_note;
  logic [DIV_W-1:0] cur_div, nxt_div;
  logic [DUR_W-1:0] cur_dur, nxt_dur, dur_last;
  logic [ID_W-1:0]  win;
  logic             accept;
  logic             toggle;
  logic             note_end;

  assign idx_inc   = idx_reg + 1'b1;
  assign last_note = (idx_reg == IDX_W'(NOTES-1));
  assign cur_div   = div_tab[sfx_id_reg][idx_reg];
  assign cur_dur   = dur_tab[sfx_id_reg][idx_reg];
  assign nxt_div   = last_note ? '0 : div_tab[sfx_id_reg][idx_inc];
  assign nxt_dur   = last_note ? '0 : dur_tab[sfx_id_reg][idx_inc];
  // A zero duration plays as a single toggle.
  assign dur_last  = (dur_reg == '0) ? '0 : dur_reg - 1'b1;
  assign toggle    = (state_reg == PLAY) && (cnt_reg == div_reg - 1'b1);
  assign note_end  = toggle && (tog_reg == dur_last);

  always_comb begin
    win = '0;
    for (int i = NUM_SFX-1; i >= 0; i--) begin
      if (trig[i]) win = ID_W'(i);
    end
  end

  assign accept = (|trig) && ((state_reg == IDLE) || (win <= sfx_id_reg));

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    tog_next    = tog_reg;
    idx_next    = idx_reg;
    sfx_id_next = sfx_id_reg;
    div_next    = div_reg;
    dur_next    = dur_reg;
    phase_next  = phase_reg;
    beep_next   = mute ? 1'b0 : beep_reg;
    done_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        beep_next  = 1'b0;
        phase_next = 1'b0;
      end
      LOAD: begin
        if (cur_div == '0) begin
          state_next = IDLE;
          beep_next  = 1'b0;
          phase_next = 1'b0;
        end else begin
          div_next   = cur_div;
          dur_next   = cur_dur;
          cnt_next   = '0;
          tog_next   = '0;
          state_next = PLAY;
        end
      end
      PLAY: begin
        if (toggle) begin
          cnt_next   = '0;
          tog_next   = tog_reg + 1'b1;
          phase_next = ~phase_reg;
          beep_next  = mute ? 1'b0 : ~phase_reg;
          if (note_end) begin
            if (last_note || (nxt_div == '0)) begin
              state_next = IDLE;
              beep_next  = 1'b0;
              phase_next = 1'b0;
              done_next  = 1'b1;
            end else begin
              idx_next = idx_inc;
              div_next = nxt_div;
              dur_next = nxt_dur;
              tog_next = '0;
            end
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // A new effect wins over everything except the completion pulse.
    if (accept) begin
      state_next  = LOAD;
      sfx_id_next = win;
      idx_next    = '0;
      cnt_next    = '0;
      tog_next    = '0;
      beep_next   = 1'b0;
      phase_next  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      tog_reg    <= '0;
      idx_reg    <= '0;
      sfx_id_reg <= '0;
      div_reg    <= '0;
      dur_reg    <= '0;
      phase_reg  <= 1'b0;
      beep_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      tog_reg    <= tog_next;
      idx_reg    <= idx_next;
      sfx_id_reg <= sfx_id_next;
      div_reg    <= div_next;
      dur_reg    <= dur_next;
      phase_reg  <= phase_next;
      beep_reg   <= beep_next;
      done_reg   <= done_next;
    end
  end

  assign beep   = beep_reg;
  assign busy   = (state_reg != IDLE);
  assign sfx_id = sfx_id_reg;
  assign done   = done_reg;

endmodule

// File: tb/tb_sfx_player.sv
// Directed bench for sfx_player: per-cycle vector table plus multi-cycle
// sequences for preemption, retrigger, mute, completion overlap and reset.
module tb_sfx_player;

  // sfx0 = {(3,4),(2,2)}, sfx1 = {(5,2),(0,0)}
  localparam logic [63:0] TABLE = 64'h0000_0502_0202_0304;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] trig;
  logic       mute;
  logic       beep;
  logic       busy;
  logic [0:0] sfx_id;
  logic       done;

  int errors = 0;
  int checks = 0;

  sfx_player #(
    .NUM_SFX(2), .NOTES(2), .DIV_W(8), .DUR_W(8), .NOTE_TABLE(TABLE)
  ) dut (
    .clk(clk), .rst(rst), .trig(trig), .mute(mute),
    .beep(beep), .busy(busy), .sfx_id(sfx_id), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] trig;
    logic       mute;
    logic       beep;
    logic       busy;
    logic       done;
    logic       id;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [1:0] t, input logic m, input logic b,
                     input logic bz, input logic d, input logic id, input int n);
    vec_t v;
    v.trig = t; v.mute = m; v.beep = b; v.busy = bz; v.done = d; v.id = id;
    for (int i = 0; i < n; i++) begin
      vecs.push_back(v);
      v.trig = 2'b00;
    end
  endtask

  task automatic check(input string name, input int j, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s step %0d got %0b want %0b", name, j, got, want);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs sampled at the same point.
  task automatic step(input logic [1:0] t, input logic m);
    trig = t;
    mute = m;
    @(posedge clk);
    #1;
    trig = 2'b00;
  endtask

  // Bit j of each pattern is the expected output after edge k+j.
  task automatic run_case(input string name, input int n,
                          input int ja, input logic [1:0] ta,
                          input int jb, input logic [1:0] tbv,
                          input int mlo, input int mhi,
                          input logic [31:0] bp, input logic [31:0] zp,
                          input logic [31:0] dp, input logic [31:0] ip);
    int e0;
    e0 = errors;
    for (int j = 0; j < n; j++) begin
      logic [1:0] t;
      t = (j == ja) ? ta : ((j == jb) ? tbv : 2'b00);
      step(t, (j >= mlo) && (j <= mhi));
      check({name, ".beep"}, j, beep, bp[j]);
      check({name, ".busy"}, j, busy, zp[j]);
      check({name, ".done"}, j, done, dp[j]);
      check({name, ".id"},   j, sfx_id[0], ip[j]);
    end
    $display("case %s: %0d cycles, %0d new errors", name, n, errors - e0);
  endtask

  initial begin
    rst  = 1'b1;
    trig = 2'b00;
    mute = 1'b0;

    // sfx0 from idle: toggles at k+4,7,10,13,15,17; done at k+17
    add(2'b01, 0, 0, 1, 0, 0, 1);
    add(2'b00, 0, 0, 1, 0, 0, 3);
    add(2'b00, 0, 1, 1, 0, 0, 3);
    add(2'b00, 0, 0, 1, 0, 0, 3);
    add(2'b00, 0, 1, 1, 0, 0, 3);
    add(2'b00, 0, 0, 1, 0, 0, 2);
    add(2'b00, 0, 1, 1, 0, 0, 2);
    add(2'b00, 0, 0, 0, 1, 0, 1);
    add(2'b00, 0, 0, 0, 0, 0, 1);
    // sfx1: toggles at k+6 and k+11, end marker finishes it at k+11
    add(2'b10, 0, 0, 1, 0, 1, 1);
    add(2'b00, 0, 0, 1, 0, 1, 5);
    add(2'b00, 0, 1, 1, 0, 1, 5);
    add(2'b00, 0, 0, 0, 1, 1, 1);
    add(2'b00, 0, 0, 0, 0, 1, 1);

    repeat (2) @(posedge clk);
    #1;
    check("rst.beep", 0, beep, 1'b0);
    check("rst.busy", 0, busy, 1'b0);
    check("rst.done", 0, done, 1'b0);
    check("rst.id",   0, sfx_id[0], 1'b0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].trig, vecs[i].mute);
      check("vec.beep", i, beep, vecs[i].beep);
      check("vec.busy", i, busy, vecs[i].busy);
      check("vec.done", i, done, vecs[i].done);
      check("vec.id",   i, sfx_id[0], vecs[i].id);
      $display("vec %0d trig=%b mute=%b beep=%b busy=%b done=%b id=%0d",
               i, vecs[i].trig, vecs[i].mute, beep, busy, done, sfx_id);
    end

    // sfx1 preempted by sfx0 at k+8: sfx0 toggles from k+12, no sfx1 done
    run_case("preempt", 27, 0, 2'b10, 8, 2'b01, 1, 0,
             32'h019C70C0, 32'h01FFFFFF, 32'h02000000, 32'h000000FF);
    // lower-priority trigger during sfx0 is dropped
    run_case("ignore_low", 19, 0, 2'b01, 5, 2'b10, 1, 0,
             32'h00019C70, 32'h0001FFFF, 32'h00020000, 32'h00000000);
    // simultaneous triggers: sfx0 wins
    run_case("both", 19, 0, 2'b11, -1, 2'b00, 1, 0,
             32'h00019C70, 32'h0001FFFF, 32'h00020000, 32'h00000000);
    // retrigger sfx0 at k+9 restarts at note 0
    run_case("retrig", 28, 0, 2'b01, 9, 2'b01, 1, 0,
             32'h0338E070, 32'h03FFFFFF, 32'h04000000, 32'h00000000);
    // mute k+5..k+9 silences beep, toggle timing unchanged afterwards
    run_case("mute", 19, 0, 2'b01, -1, 2'b00, 5, 9,
             32'h00019C10, 32'h0001FFFF, 32'h00020000, 32'h00000000);
    // trigger on the completion edge of sfx1: done pulses, sfx0 loads
    run_case("overlap", 30, 0, 2'b10, 11, 2'b01, 1, 0,
             32'h0CE387C0, 32'h0FFFFFFF, 32'h10000800, 32'h000007FF);

    // asynchronous reset in the middle of a note
    step(2'b01, 1'b0);
    repeat (5) step(2'b00, 1'b0);
    check("midrst.pre_beep", 5, beep, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("midrst.beep", 0, beep, 1'b0);
    check("midrst.busy", 0, busy, 1'b0);
    check("midrst.done", 0, done, 1'b0);
    check("midrst.id",   0, sfx_id[0], 1'b0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    $display("mid-note reset applied");
    run_case("after_rst", 19, 0, 2'b01, -1, 2'b00, 1, 0,
             32'h00019C70, 32'h0001FFFF, 32'h00020000, 32'h00000000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
